// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter: mono 10-bit offset-binary sample sent on both channels of a 64-bit frame
// Optional build macro I2S_TX_LJ_EN selects left-justified slot format instead of standard I2S.
module i2s_tx #(
  parameter int BCLK_HALF = 24
) (
  input  logic       clk_150,
  input  logic       reset,
  input  logic       audio_tick,
  input  logic [9:0] audio_sample,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_data,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(BCLK_HALF - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic          tick_s1_q, tick_s2_q, tick_prev_q;
  logic [15:0]   word_q, word_d;
  logic [15:0]   pend_word_q, pend_word_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic [5:0]    pos_q, pos_d;
  logic          out_bclk_q, out_bclk_d;
  logic          out_lrck_q, out_lrck_d;
  logic          out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          tick_edge;

  // Offset binary to signed: flip the MSB, left-align into 16 bits.
  function automatic logic [15:0] conv(input logic [9:0] s);
    conv = {~s[9], s[8:0], 6'b0};
  endfunction

  // Serial bit for slot position q of the given word.
  function automatic logic bit_of(input logic [15:0] w, input logic [4:0] q);
    logic [3:0] idx;
    bit_of = 1'b0;
`ifdef I2S_TX_LJ_EN
    idx = 4'(5'd15 - q);
    if (q <= 5'd15) bit_of = w[idx];
`else
    idx = 4'(5'd16 - q);
    if (q >= 5'd1 && q <= 5'd16) bit_of = w[idx];
`endif
  endfunction

  // State, synchroniser and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_150 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
      word_q      <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      bclk_q      <= 1'b0;
      pos_q       <= '0;
      out_bclk_q  <= 1'b0;
      out_lrck_q  <= 1'b0;
      out_data_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_s1_q   <= audio_tick;
      tick_s2_q   <= tick_s1_q;
      tick_prev_q <= tick_s2_q;
      word_q      <= word_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
      bclk_q      <= bclk_d;
      pos_q       <= pos_d;
      out_bclk_q  <= out_bclk_d;
      out_lrck_q  <= out_lrck_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: frame sequencing, pending/overrun handling, and output values for the next cycle.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    cnt_d       = cnt_q;
    bclk_d      = bclk_q;
    pos_d       = pos_q;
    tick_edge   = tick_s2_q & ~tick_prev_q;

    case (state_q)
      IDLE: begin
        // Counters are already zero here, so a start only needs the word.
        if (pend_q) begin
          state_d = SHIFT;
          word_d  = pend_word_q;
          pend_d  = 1'b0;
        end else if (tick_edge) begin
          state_d = SHIFT;
          word_d  = conv(audio_sample);
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_M1) begin
          cnt_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            if (pos_q == 6'd63) begin
              pos_d = '0;
              if (pend_q) begin
                word_d = pend_word_q;
                pend_d = 1'b0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              pos_d = pos_q + 6'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Edges that cannot start a frame directly (including one on the frame-end cycle) go to pending.
    if (tick_edge && (state_q == SHIFT || pend_q)) begin
      pend_word_d = conv(audio_sample);
      pend_d      = 1'b1;
      ovr_d       = 1'b1;
    end

    busy_d     = (state_d == SHIFT);
    out_bclk_d = busy_d & bclk_d;
    out_lrck_d = busy_d & pos_d[5];
    out_data_d = busy_d & bit_of(word_d, pos_d[4:0]);
  end

  assign i2s_bclk = out_bclk_q;
  assign i2s_lrck = out_lrck_q;
  assign i2s_data = out_data_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized scoreboard bench for i2s_tx with frame-decoding monitor
module tb_i2s_tx;

  localparam int BH = 24;
  localparam int LIMIT = 20000;

  logic       clk_150 = 1'b0;
  logic       reset;
  logic       audio_tick;
  logic [9:0] audio_sample;
  logic       i2s_bclk, i2s_lrck, i2s_data, busy, overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] sb[$];

  i2s_tx #(.BCLK_HALF(BH)) dut (
    .clk_150(clk_150), .reset(reset), .audio_tick(audio_tick), .audio_sample(audio_sample),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data), .busy(busy), .overrun(overrun)
  );

  always #3 clk_150 = ~clk_150;
  always @(posedge clk_150) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: signed value (s - 512) scaled to 16-bit full scale.
  function automatic logic [15:0] model(input logic [9:0] s);
    int v;
    v = (int'(s) - 512) * 64;
    return v[15:0];
  endfunction

  // Monitor: collect one bit per rising bclk, decode each 64-bit frame against the scoreboard.
  int   p = 0;
  int   last_rise = 0;
  int   bad_per = 0;
  logic prevb_m = 1'b0;
  logic bits[64];
  logic lrs[64];

  task automatic check_frame();
    logic [15:0] left, right, exp;
    int lr_bad, zero_bad;
    left = '0; right = '0; lr_bad = 0; zero_bad = 0;
    for (int i = 0; i < 64; i++) begin
      int q;
      q = i % 32;
      if (lrs[i] !== (i >= 32)) lr_bad++;
`ifdef I2S_TX_LJ_EN
      if (q < 16) begin
        if (i < 32) left[15-q] = bits[i]; else right[15-q] = bits[i];
      end else if (bits[i] !== 1'b0) zero_bad++;
`else
      if (q >= 1 && q <= 16) begin
        if (i < 32) left[16-q] = bits[i]; else right[16-q] = bits[i];
      end else if (bits[i] !== 1'b0) zero_bad++;
`endif
    end
    check("frame_expected", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check("left_word", left, exp);
      check("right_word", right, exp);
    end
    check("lrck_pattern_errors", lr_bad, 0);
    check("idle_slot_bits_nonzero", zero_bad, 0);
    check("bclk_period_errors", bad_per, 0);
  endtask

  always @(negedge clk_150) begin
    if (reset) begin
      p = 0;
      bad_per = 0;
      prevb_m = 1'b0;
    end else begin
      if (i2s_bclk && !prevb_m) begin
        if (p > 0 && (cyc - last_rise) != 2 * BH) bad_per++;
        last_rise = cyc;
        bits[p] = i2s_data;
        lrs[p] = i2s_lrck;
        p++;
        if (p == 64) begin
          check_frame();
          p = 0;
          bad_per = 0;
        end
      end
      prevb_m = i2s_bclk;
    end
  end

  // Issue up to three ticks at cycle offsets t0..t2; measure start latency, busy length and bclk rises.
  task automatic run_burst(input int n, input int t0, input int t1, input int t2,
                           input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2,
                           output int lat, output int busy_cyc, output int rises);
    int   k, last_t, tt[3];
    logic seen, prevb;
    logic [9:0] ss[3];
    tt[0] = t0; tt[1] = t1; tt[2] = t2;
    ss[0] = s0; ss[1] = s1; ss[2] = s2;
    last_t = tt[n-1];
    k = 0; lat = -1; busy_cyc = 0; rises = 0; seen = 1'b0; prevb = 1'b0;
    @(negedge clk_150);
    while (k < LIMIT) begin
      for (int i = 0; i < n; i++) begin
        if (k == tt[i]) begin audio_sample = ss[i]; audio_tick = 1'b1; end
        if (k == tt[i] + 5) audio_tick = 1'b0;
      end
      @(negedge clk_150);
      k++;
      if (i2s_bclk && !prevb) rises++;
      prevb = i2s_bclk;
      if (busy) begin
        busy_cyc++;
        if (!seen) begin seen = 1'b1; lat = k; end
      end else if (seen && k > last_t + 5) begin
        break;
      end
    end
    audio_tick = 1'b0;
    check("burst_completed", k < LIMIT, 1);
  endtask

  int lat, bc, rs, bad;
  logic [9:0] s, sa, sb_, sc;
  logic [9:0] dir[3];

  initial begin
    reset = 1'b1; audio_tick = 1'b0; audio_sample = '0;
    repeat (5) @(negedge clk_150);
    check("reset_outputs", {i2s_bclk, i2s_lrck, i2s_data, busy, overrun}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_150);

    dir[0] = 10'h200; dir[1] = 10'h3FF; dir[2] = 10'h000;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(dir[i]));
      run_burst(1, 0, 0, 0, dir[i], 10'h0, 10'h0, lat, bc, rs);
      check("start_latency", lat, 3);
      check("busy_cycles", bc, 64 * 2 * BH);
      check("bclk_rises", rs, 64);
    end

    for (int i = 0; i < 6; i++) begin
      s = 10'($urandom);
      sb.push_back(model(s));
      run_burst(1, 0, 0, 0, s, 10'h0, 10'h0, lat, bc, rs);
      check("rand_busy_cycles", bc, 64 * 2 * BH);
    end
    check("no_overrun_yet", overrun, 0);

    sa = 10'($urandom); sb_ = 10'($urandom); sc = 10'($urandom);
    sb.push_back(model(sa));
    sb.push_back(model(sc));
    run_burst(3, 0, 1000, 1500, sa, sb_, sc, lat, bc, rs);
    check("ovr_start_latency", lat, 3);
    check("ovr_busy_back_to_back", bc, 2 * 64 * 2 * BH);
    check("ovr_bclk_rises", rs, 128);
    check("overrun_set", overrun, 1);
    repeat (20) @(negedge clk_150);
    check("scoreboard_drained", sb.size(), 0);
    check("overrun_sticky", overrun, 1);

    audio_sample = 10'($urandom); audio_tick = 1'b1;
    repeat (5) @(negedge clk_150);
    audio_tick = 1'b0;
    repeat (800) @(negedge clk_150);
    check("midframe_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("reset_midframe_outputs", {i2s_bclk, i2s_lrck, i2s_data, busy, overrun}, 0);
    repeat (3) @(negedge clk_150);
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk_150);
      if ({i2s_bclk, i2s_lrck, i2s_data, busy, overrun} != 5'b0) bad++;
    end
    check("quiet_after_reset", bad, 0);

    s = 10'($urandom);
    sb.push_back(model(s));
    run_burst(1, 0, 0, 0, s, 10'h0, 10'h0, lat, bc, rs);
    check("post_reset_latency", lat, 3);
    check("post_reset_busy", bc, 64 * 2 * BH);
    repeat (10) @(negedge clk_150);
    check("final_drained", sb.size(), 0);
    check("overrun_cleared", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameter BCLK_HALF, default 24: clk_150 cycles per BCLK half-period, legal range 2..40.
Ports (name, direction, width, meaning):
REQ-002 SHALL have clk_150, input, 1: 150 MHz system clock; all logic is synchronous to it.
REQ-003 SHALL have reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have audio_tick, input, 1: 48 kHz sample clock from the audio engine, asynchronous to clk_150.
REQ-005 SHALL have audio_sample, input, 10: unsigned offset-binary mono sample, stable between audio_tick rising edges.
REQ-006 SHALL have i2s_bclk, output, 1: serial bit clock.
REQ-007 SHALL have i2s_lrck, output, 1: word select; 0 = left, 1 = right.
REQ-008 SHALL have i2s_data, output, 1: serial data, MSB first.
REQ-009 SHALL have busy, output, 1: high while a frame is being shifted.
REQ-010 SHALL have overrun, output, 1: sticky flag, set when a tick arrives while busy.

Function
REQ-011 SHALL synchronise audio_tick through 2 flip-flops; a rising edge is detected on cycle N when the synchronised value goes 0->1.
REQ-012 SHALL capture audio_sample at cycle N+1 and convert it to 16-bit signed: {~s[9], s[8:0], 6'b0}.
REQ-013 SHALL use FSM states IDLE and SHIFT; a detected edge in IDLE SHALL enter SHIFT at N+1 with the captured word.
REQ-014 In IDLE, SHALL hold i2s_bclk=0, i2s_lrck=0, i2s_data=0, busy=0.
REQ-015 In SHIFT, i2s_bclk SHALL toggle every BCLK_HALF cycles, starting low; the first rising edge falls BCLK_HALF cycles after SHIFT entry.
REQ-016 A frame SHALL be 64 BCLK periods (64*2*BCLK_HALF cycles) with bit position p = 0..63.
REQ-017 i2s_lrck SHALL equal p[5]; i2s_data and i2s_lrck SHALL change only at falling BCLK edges (and at SHIFT entry).
REQ-018 Both channels SHALL carry the same word; slot position q = p[4:0].
REQ-019 With q=0, data SHALL be 0 (one-bit I2S delay); q=1..16 SHALL carry word bits 15..0; q=17..31 SHALL carry 0.
REQ-020 After the high phase of p=63 completes, bclk SHALL go low and the FSM SHALL return to IDLE; busy SHALL be high exactly while in SHIFT.
REQ-021 An edge detected during SHIFT SHALL store its sample in a pending register, set pending, and set overrun.
REQ-022 If pending is set at frame end, the next frame SHALL start on the following cycle with the pending word, and pending SHALL clear.
REQ-023 A further edge while pending is set SHALL overwrite the pending word; only the latest sample is sent.
REQ-024 An edge detected on the same cycle the frame ends SHALL be treated as arriving during SHIFT (pending path).
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, with all outputs 0, pending cleared, synchroniser flops cleared, and counters at 0, including mid-frame.
REQ-027 After reset is released, the first audio_tick rising edge SHALL start a fresh frame at p=0.

Configuration
REQ-028 Macro I2S_TX_LJ_EN defined SHALL select left-justified format: q=0..15 carry word bits 15..0 and q=16..31 carry 0.
REQ-029 Without I2S_TX_LJ_EN, the block SHALL use standard I2S format per REQ-019; all other behaviour is identical.

Verification
REQ-030 Reset check: assert reset mid-frame -> bclk, lrck, data, busy and overrun are 0 in the same cycle, and stay 0 until a tick after release.
REQ-031 Conversion check: samples 10'h200, 10'h3FF and 10'h000 -> 0x0000, 0x7FC0 and 0x8000 decoded on both left and right slots.
REQ-032 Timing check with BCLK_HALF=24: BCLK period 48 cycles, exactly 64 rising edges, busy high 3072 cycles, first SHIFT cycle 3 cycles after the audio_tick edge reaches the synchroniser input.
REQ-033 Overrun check: second tick 1000 cycles after the first -> overrun=1, second frame starts 1 cycle after the first ends, carries the second sample, and overrun persists until reset.
REQ-034 Format check: sample 10'h3FF -> MSB (0) at q=1 and lrck transitions at p=32 and p=0; with I2S_TX_LJ_EN defined, MSB at q=0.
